// File: rtl/dm_resp.sv
// dm_resp: word-addressed data memory behind a req/ack handshake that inserts
// WAIT wait cycles before every access and flags out-of-range addresses.
module dm_resp #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic        lat_we;
    logic [9:0]  lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        access;
    logic        in_range;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH];

    // Handshake: the requester raises req with we/addr/be/wdata and holds req
    // until ack; the request is captured on the first edge seen in IDLE, ack
    // pulses for one cycle WAIT+1 edges later, and req is ignored while busy.
    assign busy     = (state != IDLE);
    assign in_range = 32'(lat_addr) < DEPTH;
    assign idx      = lat_addr[AW-1:0];

    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = WAITING;
            end
            WAITING: begin
                if (cnt == 3'd0) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
            lat_we    <= 1'b0;
            lat_addr  <= 10'h0;
            lat_be    <= 4'h0;
            lat_wdata <= 32'h0;
        end else begin
            state <= state_next;
            ack   <= access;
            err   <= access && !in_range;
            if (state == IDLE && req) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_be    <= be;
                lat_wdata <= wdata;
                cnt       <= 3'(WAIT);
            end else if (state == WAITING && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (access && !lat_we) begin
                rdata <= in_range ? mem[idx] : 32'h0;
            end
        end
    end

    // Memory is deliberately outside the reset domain; an async reset forces
    // IDLE before any later edge, so an aborted access never reaches here.
    always_ff @(posedge clk) begin
        if (access && lat_we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: two instances (DEPTH=512/WAIT=2 and DEPTH=1024/WAIT=0)
// driven with directed and random accesses against a word-array reference.
module tb_dm_resp;
    localparam int DEPTH_A = 512;
    localparam int WAIT_A  = 2;
    localparam int DEPTH_B = 1024;
    localparam int WAIT_B  = 0;

    typedef struct {
        int          accept;
        int          ack_cycle;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [9:0]  addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        busy  [2];

    dm_resp #(.DEPTH(DEPTH_A), .WAIT(WAIT_A)) dut_a (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .be(be[0]), .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]),
        .err(err[0]), .busy(busy[0])
    );

    dm_resp #(.DEPTH(DEPTH_B), .WAIT(WAIT_B)) dut_b (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .be(be[1]), .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]),
        .err(err[1]), .busy(busy[1])
    );

    // scoreboard state and reference model
    exp_t        exp_q_a[$];
    exp_t        exp_q_b[$];
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];
    int          free [2];
    bit          busy_chk [2];
    int          checks   = 0;
    int          failures = 0;

    function automatic int wait_of(input int k);
        return (k == 0) ? WAIT_A : WAIT_B;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic void check(input string name, input int k,
                                  input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cycle=%0d actual=%h expected=%h",
                     name, k, cyc, act, exp);
        end
    endfunction

    // monitor: busy follows the in-flight access, ack only on its cycle
    function automatic void mon_step(input int k);
        exp_t e;
        bit   have;
        have = (k == 0) ? (exp_q_a.size() > 0) : (exp_q_b.size() > 0);
        if (have) e = (k == 0) ? exp_q_a[0] : exp_q_b[0];
        if (busy_chk[k])
            check("busy", k, 32'(busy[k]),
                  32'(have && cyc >= e.accept && cyc <= e.ack_cycle));
        if (have && cyc == e.ack_cycle) begin
            check("ack", k, 32'(ack[k]), 32'd1);
            check("err", k, 32'(err[k]), 32'(e.err));
            check("rdata", k, rdata[k], e.rdata);
            if (k == 0) void'(exp_q_a.pop_front());
            else        void'(exp_q_b.pop_front());
        end else begin
            check("no_ack", k, 32'(ack[k]), 32'd0);
        end
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    // driver: called at a falling edge, returns at the falling edge after ack
    task automatic do_access(input int k, input bit w, input logic [9:0] a,
                             input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        int   acc;
        bit   ok;
        acc         = (cyc + 1 > free[k]) ? cyc + 1 : free[k];
        e.accept    = acc;
        e.ack_cycle = acc + wait_of(k) + 1;
        free[k]     = e.ack_cycle + 2;
        ok          = int'(a) < depth_of(k);
        e.err       = !ok;
        if (w) begin
            if (ok) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
            end
            e.rdata = last_rd[k];
        end else begin
            e.rdata    = ok ? mdl[k][a] : 32'h0;
            last_rd[k] = e.rdata;
        end
        if (k == 0) exp_q_a.push_back(e);
        else        exp_q_b.push_back(e);
        we[k]    = w;
        addr[k]  = a;
        be[k]    = b;
        wdata[k] = d;
        req[k]   = 1'b1;
        while (cyc < e.ack_cycle) begin
            @(negedge clk);
            if (cyc >= acc && cyc < e.ack_cycle) begin
                we[k]    = 1'($urandom_range(0, 1));
                addr[k]  = 10'($urandom);
                be[k]    = 4'($urandom);
                wdata[k] = $urandom;
            end
        end
        req[k] = 1'b0;
    endtask

    task automatic reset_abort();
        while (cyc + 1 < free[0]) @(negedge clk);
        busy_chk[0] = 1'b0;
        we[0]    = 1'b1;
        addr[0]  = 10'd9;
        be[0]    = 4'hf;
        wdata[0] = 32'h12345678;
        req[0]   = 1'b1;
        @(negedge clk);
        check("abort_busy_waiting", 0, 32'(busy[0]), 32'd1);
        @(negedge clk);
        rst[0] = 1'b1;
        req[0] = 1'b0;
        #1;
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
        check("abort_ack", 0, 32'(ack[0]), 32'd0);
        check("abort_err", 0, 32'(err[0]), 32'd0);
        check("abort_rdata", 0, rdata[0], 32'h0);
        @(negedge clk);
        rst[0]      = 1'b0;
        last_rd[0]  = 32'h0;
        free[0]     = cyc + 1;
        busy_chk[0] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int k;
        logic [9:0] a;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = 10'h0;
            be[i] = 4'h0; wdata[i] = 32'h0; busy_chk[i] = 1'b0; last_rd[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", i, 32'(ack[i]), 32'd0);
            check("rst_err", i, 32'(err[i]), 32'd0);
            check("rst_busy", i, 32'(busy[i]), 32'd0);
            check("rst_rdata", i, rdata[i], 32'h0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; free[i] = cyc + 1; busy_chk[i] = 1'b1;
        end

        // prefill the address window used by reads
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) do_access(i, 1'b1, 10'(j), 4'hf, $urandom);
        do_access(0, 1'b1, 10'd88, 4'hf, $urandom);

        do_access(0, 1'b1, 10'd5, 4'hf, 32'hDEADBEEF);
        do_access(0, 1'b0, 10'd5, 4'h0, 32'h0);
        do_access(0, 1'b1, 10'd7, 4'hf, 32'h11223344);
        do_access(0, 1'b1, 10'd7, 4'b0101, 32'hAABBCCDD);
        do_access(0, 1'b0, 10'd7, 4'hf, 32'h0);
        do_access(0, 1'b1, 10'd3, 4'h0, 32'hFFFFFFFF);
        do_access(0, 1'b0, 10'd3, 4'h0, 32'h0);
        do_access(0, 1'b1, 10'd600, 4'hf, 32'hCAFEF00D);
        do_access(0, 1'b0, 10'd600, 4'hf, 32'h0);
        do_access(0, 1'b0, 10'd88, 4'hf, 32'h0);

        reset_abort();
        do_access(0, 1'b0, 10'd9, 4'h0, 32'h0);

        do_access(1, 1'b0, 10'd3, 4'h0, 32'h0);
        do_access(1, 1'b0, 10'd4, 4'h0, 32'h0);
        do_access(1, 1'b1, 10'd1023, 4'hf, 32'h5A5AA5A5);

        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 1);
            if (k == 0 && $urandom_range(0, 3) == 0) a = 10'($urandom_range(512, 1023));
            else a = 10'($urandom_range(0, 15));
            do_access(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        for (int t = 0; t < 50 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); t++)
            @(negedge clk);
        check("drain_a", 0, 32'(exp_q_a.size()), 32'd0);
        check("drain_b", 1, 32'(exp_q_b.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
